sdb_chunk_sequencer: RTL
========================

Name: sdb_chunk_sequencer

Overview:
- Word-serial front/back end for the sdb_inner carry-select adder.
- Accepts a wide operand pair over a valid/ready handshake and splits it into WIDTH-bit chunks.
- Drives one chunk per cycle into the adder, including the precomputed propagate vector p = a ^ b, and chains the adder's c_out back into the next chunk's c_in.
- Assembles the sum chunks into a full-width result and presents it on a valid/ready output.

Parameters:
- WIDTH, 8: chunk width; must match the adder instance; even and > 2.
- CHUNKS, 4: number of chunks per operand; >= 2; total operand width OP_W = WIDTH*CHUNKS.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  sequencer can accept operands.
- in_a  input  OP_W  operand A, bit 0 = LSB.
- in_b  input  OP_W  operand B.
- in_cin  input  1  carry-in for chunk 0.
- add_c_in  output  1  carry into the adder for the current chunk.
- add_a  output  WIDTH  current chunk of A; add_a[i] = bit i of the chunk.
- add_b  output  WIDTH  current chunk of B.
- add_p  output  WIDTH  add_a ^ add_b.
- add_s  input  WIDTH  adder sum for the current chunk (combinational return).
- add_c_out  input  1  adder carry-out for the current chunk.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  OP_W  assembled sum.
- out_cout  output  1  carry-out of the last chunk.

Behaviour:
- Reset:
  - state=IDLE; idx=0; carry=0; operand and sum registers cleared.
  - in_ready=1; out_valid=0; out_sum=0; out_cout=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_a, in_b; carry<=in_cin; idx<=0; go to RUN.
- RUN:
  - in_ready=0.
  - Adder outputs driven combinationally from registers: add_a/add_b = chunk idx; add_p = add_a ^ add_b; add_c_in = carry.
  - Each cycle: sum[idx*WIDTH +: WIDTH] <= add_s; carry <= add_c_out; idx <= idx+1.
  - At idx==CHUNKS-1: capture that chunk, out_cout <= add_c_out, go to DONE.
- DONE:
  - out_valid=1; out_sum and out_cout held stable.
  - On out_ready: go to IDLE (out_valid drops next cycle).
  - in_ready=0 throughout DONE; no accept in the same cycle as result handoff.
- Idle drive: outside RUN, add_a=add_b=add_p=0 and add_c_in=0.
- Timing:
  - Latency: out_valid asserts exactly CHUNKS+1 cycles after the accepting edge.
  - Throughput: one operation per CHUNKS+2 cycles minimum.
- Width rules:
  - idx is $clog2(CHUNKS) bits; it never wraps past CHUNKS-1.
  - Sum is modulo 2^OP_W; the carry is reported only via out_cout.
- Boundary conditions:
  - in_valid deasserted in RUN/DONE is ignored; operands are registered, so input changes after accept have no effect.
  - out_ready held high before DONE is harmless; handoff occurs on the first DONE cycle.
  - Reset asserted mid-RUN or mid-DONE aborts immediately to reset values; the partial result is discarded.
  - add_s/add_c_out are sampled only in RUN.

Optional Feature:
- Macro: SDB_CHUNK_SEQ_OVF_EN.
- With the macro:
  - Extra output out_ovf (1 bit), registered at the last chunk.
  - Value: two's-complement signed overflow = carry into MSB ^ carry out of MSB, computed as in_a[MSB] ^ in_b[MSB] ^ sum[MSB] ^ add_c_out.
  - Reset 0; held with out_sum.
- Without the macro: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package sdb_pkg holds:
  - state enum (IDLE, RUN, DONE), 2-bit;
  - function computing the OP_W slice offset from idx.
- No sub-module. The adder is instantiated by the parent, which maps the packed add_* vectors to the adder's unpacked arrays with identical index order.

Test Plan (WIDTH=8, CHUNKS=4, bench instantiates real sdb_inner behind the sequencer):
- 0x000000FF + 0x00000001, cin=0 -> out_sum=0x00000100, out_cout=0; carry visible on add_c_in=1 in chunk-1 cycle; out_valid at accept+5.
- 0xFFFFFFFF + 0x00000001, cin=0 -> out_sum=0x00000000, out_cout=1; add_c_in=1 in chunks 1..3.
- 0x00000000 + 0x00000000, cin=1 -> out_sum=0x00000001, out_cout=0; add_p=0x00 every RUN cycle.
- Result 0x12345678+0x11111111=0x23456789 with out_ready low 5 cycles -> out_valid and out_sum stable and in_ready=0 throughout; IDLE one cycle after out_ready.
- rst_n pulsed low at idx=2 -> out_valid=0, in_ready=1, out_sum=0 immediately; next op 0x1+0x1 -> 0x2 correct.
- With SDB_CHUNK_SEQ_OVF_EN: 0x7FFFFFFF+0x00000001 -> out_ovf=1, out_cout=0; 0xFFFFFFFF+0x00000001 -> out_ovf=0, out_cout=1.

Source files
------------

// File: rtl/sdb_pkg.sv
// Shared types and helpers for the sdb chunk sequencer.
package sdb_pkg;

    // Sequencer control states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } sdb_state_e;

    // Bit offset of chunk idx within the full-width operand.
    function automatic int unsigned chunk_offset(input int unsigned idx,
                                                 input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/sdb_inner.sv
// Carry-select adder slice: the low half ripples from c_i, and the high half is
// computed for both possible carries and then muxed by the low-half carry.
// p_i must equal a_i ^ b_i; the caller precomputes it.
module sdb_inner #(
    parameter int unsigned WIDTH = 8
) (
    input  logic a_i [WIDTH],
    input  logic b_i [WIDTH],
    input  logic p_i [WIDTH],
    input  logic c_i,
    output logic s_o [WIDTH],
    output logic c_o
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned HI_W = WIDTH - HALF;

    logic            lo_c;
    logic            hi_c0;
    logic            hi_c1;
    logic [HI_W-1:0] s0;
    logic [HI_W-1:0] s1;

    // Ripple the low half, speculate the high half for both carries, then select.
    always_comb begin
        s_o   = '{default: 1'b0};
        lo_c  = c_i;
        hi_c0 = 1'b0;
        hi_c1 = 1'b1;
        s0    = '0;
        s1    = '0;
        for (int i = 0; i < int'(HALF); i++) begin
            s_o[i] = p_i[i] ^ lo_c;
            lo_c   = (a_i[i] & b_i[i]) | (p_i[i] & lo_c);
        end
        for (int i = int'(HALF); i < int'(WIDTH); i++) begin
            s0[i-int'(HALF)] = p_i[i] ^ hi_c0;
            hi_c0            = (a_i[i] & b_i[i]) | (p_i[i] & hi_c0);
            s1[i-int'(HALF)] = p_i[i] ^ hi_c1;
            hi_c1            = (a_i[i] & b_i[i]) | (p_i[i] & hi_c1);
        end
        for (int i = int'(HALF); i < int'(WIDTH); i++) begin
            s_o[i] = lo_c ? s1[i-int'(HALF)] : s0[i-int'(HALF)];
        end
        c_o = lo_c ? hi_c1 : hi_c0;
    end

endmodule

// File: rtl/sdb_chunk_sequencer.sv
// Word-serial front/back end for the sdb_inner adder. Splits a wide operand
// pair into WIDTH-bit chunks, feeds one chunk per cycle (carry chained), and
// assembles the full-width sum behind a valid/ready output.
// Optional: define SDB_CHUNK_SEQ_OVF_EN to add the out_ovf signed-overflow flag.
module sdb_chunk_sequencer
    import sdb_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CHUNKS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*CHUNKS-1:0]   in_a,
    input  logic [WIDTH*CHUNKS-1:0]   in_b,
    input  logic                      in_cin,
    output logic                      add_c_in,
    output logic [WIDTH-1:0]          add_a,
    output logic [WIDTH-1:0]          add_b,
    output logic [WIDTH-1:0]          add_p,
    input  logic [WIDTH-1:0]          add_s,
    input  logic                      add_c_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH*CHUNKS-1:0]   out_sum,
    output logic                      out_cout
`ifdef SDB_CHUNK_SEQ_OVF_EN
    ,
    output logic                      out_ovf
`endif
);

    localparam int unsigned OP_W  = WIDTH * CHUNKS;
    localparam int unsigned IDX_W = $clog2(CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);
    localparam logic [OP_W-1:0]  CHUNK_MASK = {{(OP_W-WIDTH){1'b0}}, {WIDTH{1'b1}}};

    sdb_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [OP_W-1:0]  a_q, a_d;
    logic [OP_W-1:0]  b_q, b_d;
    logic [OP_W-1:0]  sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SDB_CHUNK_SEQ_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    int unsigned      off;
    logic [WIDTH-1:0] a_chunk;
    logic [WIDTH-1:0] b_chunk;

    // Select the current chunk of each latched operand.
    always_comb begin
        off     = chunk_offset(32'(idx_q), WIDTH);
        a_chunk = WIDTH'(a_q >> off);
        b_chunk = WIDTH'(b_q >> off);
    end

    // Next-state, datapath updates and handshake/adder outputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
`ifdef SDB_CHUNK_SEQ_OVF_EN
        ovf_d     = ovf_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_p     = '0;
        add_c_in  = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                add_a    = a_chunk;
                add_b    = b_chunk;
                add_p    = a_chunk ^ b_chunk;
                add_c_in = carry_q;
                sum_d    = (sum_q & ~(CHUNK_MASK << off)) | (OP_W'(add_s) << off);
                carry_d  = add_c_out;
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_c_out;
`ifdef SDB_CHUNK_SEQ_OVF_EN
                    // Carry into MSB xor carry out of MSB.
                    ovf_d   = a_q[OP_W-1] ^ b_q[OP_W-1] ^ add_s[WIDTH-1] ^ add_c_out;
`endif
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SDB_CHUNK_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SDB_CHUNK_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
`ifdef SDB_CHUNK_SEQ_OVF_EN
    assign out_ovf  = ovf_q;
`endif

endmodule
